// File: rtl/pipe_skid_buf_pkg.sv
// Shared encodings for the pipeline stage skid buffers.
// Occupancy is the state encoding itself, so the two must stay in step.
package pipe_skid_buf_pkg;

  localparam int PS_OCC_W = 2;

  typedef enum logic [PS_OCC_W-1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_t;

endpackage

// File: rtl/pipe_skid_buf_sat_counter.sv
// Saturating up-counter used for per-stage stall/flush statistics.
// Holds at all-ones and clears only on rst.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_buf.sv
// 2-entry valid/ready skid buffer between pipeline stages, with flush-to-bubble.
// Optional statistics counters are built only when STAGE_STATS_EN is defined.
module pipe_skid_buf
  import pipe_skid_buf_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WIDTH-1:0]    i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WIDTH-1:0]    o_data,
  input  logic                i_flush,
  output logic [PS_OCC_W-1:0] o_occupancy,
  output logic [CNT_W-1:0]    o_stall_cnt,
  output logic [CNT_W-1:0]    o_flush_cnt
);

  ps_state_t        state;
  logic [WIDTH-1:0] skid;
  logic             accept;
  logic             emit;

  assign accept      = i_valid && o_ready;
  assign emit        = o_valid && i_ready;
  assign o_occupancy = state;

  // o_valid/o_ready are kept as flops alongside state so no combinational path crosses stages.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      state   <= PS_EMPTY;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      o_data  <= NOP_VALUE;
      skid    <= NOP_VALUE;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (accept) begin
            state   <= PS_ONE;
            o_valid <= 1'b1;
            o_data  <= i_data;
          end
        end
        PS_ONE: begin
          if (accept && emit) begin
            o_data <= i_data;
          end else if (accept) begin
            state   <= PS_TWO;
            skid    <= i_data;
            o_ready <= 1'b0;
          end else if (emit) begin
            state   <= PS_EMPTY;
            o_valid <= 1'b0;
            o_data  <= NOP_VALUE;
          end
        end
        PS_TWO: begin
          if (emit) begin
            state   <= PS_ONE;
            o_data  <= skid;
            skid    <= NOP_VALUE;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= PS_EMPTY;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          o_data  <= NOP_VALUE;
          skid    <= NOP_VALUE;
        end
      endcase
    end
  end

`ifdef STAGE_STATS_EN
  logic stall_inc;
  logic flush_inc;

  // A flush only counts if it actually discarded something, held or incoming.
  assign stall_inc = o_valid && !i_ready && !i_flush;
  assign flush_inc = i_flush && ((state != PS_EMPTY) || accept);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (stall_inc),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (flush_inc),
    .o_cnt (o_flush_cnt)
  );
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule
